// File: rtl/btn_event_pkg.sv
// -----------------------------------------------------------------------------
// btn_event_pkg
// Shared definitions for the push-button gesture controller:
//   - event codes reported on ev_code (SHORT / LONG / REPEAT; 3 is reserved)
//   - per-button press FSM state encoding
//   - event record {button index, code} stored in the event FIFO
// The event record carries a fixed 3-bit button index, enough for the largest
// supported button count (8); the top truncates it to $clog2(NBTN) bits.
// -----------------------------------------------------------------------------
package btn_event_pkg;

  localparam logic [1:0] EV_SHORT  = 2'd0;
  localparam logic [1:0] EV_LONG   = 2'd1;
  localparam logic [1:0] EV_REPEAT = 2'd2;

  localparam int EV_BTN_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_HELD    = 2'd2
  } btn_state_e;

  typedef struct packed {
    logic [EV_BTN_W-1:0] btn;
    logic [1:0]          code;
  } btn_ev_t;

endpackage

// File: rtl/btn_press_fsm.sv
// -----------------------------------------------------------------------------
// btn_press_fsm
// Gesture classifier for one debounced button plus its single pending slot.
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   btn_i      in   debounced level, 1 = pressed
//   pend_clr_i in   arbiter took the pending event this cycle
//   pend_o     out  pending slot holds an event
//   code_o     out  code of the pending event
//   drop_o     out  an event was raised while the slot was occupied (pulse)
// Build option: BTN_REPEAT_EN enables auto-repeat while held after a long
// press; without it HELD only waits for release and REP_CYC is ignored.
// -----------------------------------------------------------------------------
module btn_press_fsm
  import btn_event_pkg::*;
#(
  parameter int LONG_CYC = 5_000_000,
  parameter int REP_CYC  = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_i,
  input  logic       pend_clr_i,
  output logic       pend_o,
  output logic [1:0] code_o,
  output logic       drop_o
);

`ifdef BTN_REPEAT_EN
  localparam int MAX_CYC = (LONG_CYC > REP_CYC) ? LONG_CYC : REP_CYC;
`else
  localparam int MAX_CYC = LONG_CYC;
`endif
  // Largest value compared against is MAX_CYC-1.
  localparam int CNT_W = $clog2(MAX_CYC);

  btn_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             prev_q;
  logic             pend_q, pend_d;
  logic [1:0]       code_q, code_d;
  logic             raise;
  logic [1:0]       raise_code;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    raise      = 1'b0;
    raise_code = EV_SHORT;
    pend_d     = pend_q & ~pend_clr_i;
    code_d     = code_q;
    drop_o     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Only a fresh rising edge starts a press; prev resets to 1 so a
        // button held through reset never counts as pressed.
        if (btn_i && !prev_q) begin
          state_d = ST_PRESSED;
          cnt_d   = '0;
        end
      end
      ST_PRESSED: begin
        // Release is checked first so it wins over the long threshold.
        if (!btn_i) begin
          raise      = 1'b1;
          raise_code = EV_SHORT;
          state_d    = ST_IDLE;
        end else if (cnt_q == CNT_W'(LONG_CYC - 1)) begin
          raise      = 1'b1;
          raise_code = EV_LONG;
          state_d    = ST_HELD;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HELD: begin
        if (!btn_i) begin
          state_d = ST_IDLE;
        end
`ifdef BTN_REPEAT_EN
        else if (cnt_q == CNT_W'(REP_CYC - 1)) begin
          raise      = 1'b1;
          raise_code = EV_REPEAT;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A slot freed by the arbiter this cycle can take the new event; an
    // occupied slot keeps its event and the new one is dropped.
    if (raise) begin
      if (!pend_d) begin
        pend_d = 1'b1;
        code_d = raise_code;
      end else begin
        drop_o = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      prev_q  <= 1'b1;
      pend_q  <= 1'b0;
      code_q  <= EV_SHORT;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prev_q  <= btn_i;
      pend_q  <= pend_d;
      code_q  <= code_d;
    end
  end

  assign pend_o = pend_q;
  assign code_o = code_q;

endmodule

// File: rtl/btn_event_ctrl.sv
// -----------------------------------------------------------------------------
// btn_event_ctrl
// Classifies presses of NBTN debounced buttons into SHORT / LONG / REPEAT
// events, round-robin arbitrates the per-button pending events into a
// show-ahead FIFO, and presents the FIFO head through a valid/ready port.
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   btn_state  in   [NBTN] debounced levels, 1 = pressed
//   ev_valid   out  FIFO head holds an event
//   ev_ready   in   consumer accepts the head when ev_valid & ev_ready
//   ev_btn     out  button index of the head event
//   ev_code    out  0 SHORT, 1 LONG, 2 REPEAT
//   overflow   out  sticky, an event was dropped (cleared only by rst)
// Build option: BTN_REPEAT_EN enables REPEAT events (see btn_press_fsm).
// -----------------------------------------------------------------------------
module btn_event_ctrl
  import btn_event_pkg::*;
#(
  parameter int NBTN       = 4,
  parameter int LONG_CYC   = 5_000_000,
  parameter int REP_CYC    = 1_000_000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NBTN-1:0]         btn_state,
  output logic                    ev_valid,
  input  logic                    ev_ready,
  output logic [$clog2(NBTN)-1:0] ev_btn,
  output logic [1:0]              ev_code,
  output logic                    overflow
);

  localparam int BW = $clog2(NBTN);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  logic [NBTN-1:0] pend;
  logic [NBTN-1:0] pend_clr;
  logic [NBTN-1:0] drop;
  logic [1:0]      pend_code [NBTN];

  logic          gnt_v;
  logic [BW-1:0] gnt_idx;
  logic [BW-1:0] rr_q, rr_d;

  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  btn_ev_t       mem_q [FIFO_DEPTH];
  btn_ev_t       head, push_ev;
  logic          empty, full, push, pop;
  logic          overflow_q;

  for (genvar g = 0; g < NBTN; g++) begin : g_btn
    btn_press_fsm #(
      .LONG_CYC (LONG_CYC),
      .REP_CYC  (REP_CYC)
    ) u_fsm (
      .clk        (clk),
      .rst        (rst),
      .btn_i      (btn_state[g]),
      .pend_clr_i (pend_clr[g]),
      .pend_o     (pend[g]),
      .code_o     (pend_code[g]),
      .drop_o     (drop[g])
    );
    assign pend_clr[g] = push && (gnt_idx == BW'(g));
  end

  // Round-robin search starting at rr_q. Scanning from the farthest offset
  // down lets the nearest pending button overwrite earlier candidates.
  always_comb begin : arb
    int            j;
    logic [BW-1:0] jj;
    gnt_v   = 1'b0;
    gnt_idx = '0;
    j       = 0;
    jj      = '0;
    for (int i = NBTN - 1; i >= 0; i--) begin
      j = int'(rr_q) + i;
      if (j >= NBTN) j = j - NBTN;
      jj = BW'(j);
      if (pend[jj]) begin
        gnt_v   = 1'b1;
        gnt_idx = jj;
      end
    end
  end

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop   = !empty && ev_ready;
  // A full FIFO still accepts a grant when its head leaves the same cycle.
  assign push  = gnt_v && (!full || pop);

  always_comb begin
    push_ev      = '0;
    push_ev.btn  = EV_BTN_W'(gnt_idx);
    push_ev.code = pend_code[gnt_idx];
    wr_d         = push ? wr_q + PW'(1) : wr_q;
    rd_d         = pop  ? rd_q + PW'(1) : rd_q;
    rr_d         = rr_q;
    if (push) begin
      rr_d = (gnt_idx == BW'(NBTN - 1)) ? '0 : gnt_idx + BW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q       <= '0;
      rd_q       <= '0;
      rr_q       <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      rr_q <= rr_d;
      if (|drop) overflow_q <= 1'b1;
    end
  end

  // Storage needs no reset: the outputs are forced to zero while empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= push_ev;
  end

  assign head     = mem_q[rd_q[AW-1:0]];
  assign ev_valid = !empty;
  assign ev_btn   = empty ? '0 : BW'(head.btn);
  assign ev_code  = empty ? EV_SHORT : head.code;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_btn_event_ctrl.sv
module tb_btn_event_ctrl;
  localparam int NBTN       = 4;
  localparam int LONG_CYC   = 20;
  localparam int REP_CYC    = 5;
  localparam int FIFO_DEPTH = 4;

`ifdef BTN_REPEAT_EN
  localparam bit REP_ON = 1'b1;
`else
  localparam bit REP_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn_state = '0;
  logic       ev_valid;
  logic       ev_ready = 1'b0;
  logic [1:0] ev_btn;
  logic [1:0] ev_code;
  logic       overflow;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  btn_event_ctrl #(
    .NBTN       (NBTN),
    .LONG_CYC   (LONG_CYC),
    .REP_CYC    (REP_CYC),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_state (btn_state),
    .ev_valid  (ev_valid),
    .ev_ready  (ev_ready),
    .ev_btn    (ev_btn),
    .ev_code   (ev_code),
    .overflow  (overflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset(input logic rdy);
    rst       = 1'b1;
    btn_state = '0;
    ev_ready  = rdy;
    ticks(2);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    btn_state = '0;
    ev_ready  = 1'b1;
    ticks(2);
    n_chk++;
    if (ev_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", ev_valid);
    else n_pass++;
    n_chk++;
    if (ev_btn !== 2'd0) $display("FAIL reset_btn: got %0d want 0", ev_btn);
    else n_pass++;
    n_chk++;
    if (ev_code !== 2'd0) $display("FAIL reset_code: got %0d want 0", ev_code);
    else n_pass++;
    n_chk++;
    if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b want 0", overflow);
    else n_pass++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_short();
    do_reset(1'b1);
    btn_state[1] = 1'b1;
    ticks(10);
    btn_state[1] = 1'b0;
    tick();
    n_chk++;
    if (ev_valid !== 1'b0) $display("FAIL short_latency: valid got %b want 0 one edge after release", ev_valid);
    else n_pass++;
    tick();
    n_chk++;
    if (ev_valid !== 1'b1 || ev_btn !== 2'd1 || ev_code !== 2'd0)
      $display("FAIL short_event: got v=%b btn=%0d code=%0d want v=1 btn=1 code=0", ev_valid, ev_btn, ev_code);
    else n_pass++;
    tick();
    n_chk++;
    if (ev_valid !== 1'b0) $display("FAIL short_onecycle: valid got %b want 0", ev_valid);
    else n_pass++;
  endtask

  task automatic test_long();
    logic       exp_v;
    logic [1:0] exp_c;
    do_reset(1'b1);
    btn_state[2] = 1'b1;
    for (int t = 1; t <= 40; t++) begin
      tick();
      exp_v = (t == 22) || (REP_ON && (t == 27 || t == 32));
      exp_c = (t == 22) ? 2'd1 : 2'd2;
      n_chk++;
      if (ev_valid !== exp_v) $display("FAIL long_valid_t%0d: got %b want %b", t, ev_valid, exp_v);
      else n_pass++;
      if (exp_v) begin
        n_chk++;
        if (ev_btn !== 2'd2 || ev_code !== exp_c)
          $display("FAIL long_event_t%0d: got btn=%0d code=%0d want btn=2 code=%0d", t, ev_btn, ev_code, exp_c);
        else n_pass++;
      end
      if (t == 32) btn_state[2] = 1'b0;
    end
  endtask

  task automatic all_four_check(input int first, input string tag);
    logic [1:0] exp_b;
    btn_state = 4'hF;
    ticks(5);
    btn_state = 4'h0;
    tick();
    n_chk++;
    if (ev_valid !== 1'b0) $display("FAIL %s_pre: valid got %b want 0", tag, ev_valid);
    else n_pass++;
    for (int k = 0; k < 4; k++) begin
      tick();
      exp_b = 2'((first + k) % 4);
      n_chk++;
      if (ev_valid !== 1'b1 || ev_btn !== exp_b || ev_code !== 2'd0)
        $display("FAIL %s_%0d: got v=%b btn=%0d code=%0d want v=1 btn=%0d code=0", tag, k, ev_valid, ev_btn, ev_code, exp_b);
      else n_pass++;
    end
    tick();
    n_chk++;
    if (ev_valid !== 1'b0) $display("FAIL %s_post: valid got %b want 0", tag, ev_valid);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    do_reset(1'b1);
    all_four_check(0, "rr_from0");
    // one grant on button 1 moves the pointer to 2
    btn_state[1] = 1'b1;
    ticks(3);
    btn_state[1] = 1'b0;
    ticks(4);
    all_four_check(2, "rr_from2");
  endtask

  task automatic test_overflow();
    logic [1:0] seq [5];
    seq[0] = 2'd0; seq[1] = 2'd1; seq[2] = 2'd2; seq[3] = 2'd3; seq[4] = 2'd0;
    do_reset(1'b0);
    for (int b = 0; b < 4; b++) begin
      btn_state[b] = 1'b1;
      ticks(3);
      btn_state[b] = 1'b0;
      ticks(3);
    end
    n_chk++;
    if (ev_valid !== 1'b1 || ev_btn !== 2'd0 || overflow !== 1'b0)
      $display("FAIL ovf_full: got v=%b btn=%0d ovf=%b want v=1 btn=0 ovf=0", ev_valid, ev_btn, overflow);
    else n_pass++;
    btn_state[0] = 1'b1;
    ticks(3);
    btn_state[0] = 1'b0;
    ticks(3);
    n_chk++;
    if (overflow !== 1'b0 || ev_valid !== 1'b1) $display("FAIL ovf_pending: got ovf=%b v=%b want ovf=0 v=1", overflow, ev_valid);
    else n_pass++;
    btn_state[0] = 1'b1;
    ticks(3);
    btn_state[0] = 1'b0;
    ticks(3);
    n_chk++;
    if (overflow !== 1'b1 || ev_valid !== 1'b1 || ev_btn !== 2'd0)
      $display("FAIL ovf_set: got ovf=%b v=%b btn=%0d want ovf=1 v=1 btn=0", overflow, ev_valid, ev_btn);
    else n_pass++;
    ev_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      n_chk++;
      if (ev_valid !== 1'b1 || ev_btn !== seq[k] || ev_code !== 2'd0)
        $display("FAIL ovf_drain_%0d: got v=%b btn=%0d code=%0d want v=1 btn=%0d code=0", k, ev_valid, ev_btn, ev_code, seq[k]);
      else n_pass++;
      tick();
    end
    n_chk++;
    if (ev_valid !== 1'b0 || overflow !== 1'b1)
      $display("FAIL ovf_after_drain: got v=%b ovf=%b want v=0 ovf=1", ev_valid, overflow);
    else n_pass++;
  endtask

  task automatic test_hold_through_reset();
    int seen;
    seen      = 0;
    btn_state = 4'b1000;
    ev_ready  = 1'b1;
    rst       = 1'b1;
    ticks(2);
    rst = 1'b0;
    ticks(3);
    btn_state = 4'b0000;
    for (int t = 0; t < 10; t++) begin
      tick();
      if (ev_valid) seen++;
    end
    n_chk++;
    if (seen !== 0) $display("FAIL hold_reset_events: got %0d valid cycles want 0", seen);
    else n_pass++;
  endtask

  task automatic test_reset_mid_held();
    int seen;
    seen = 0;
    do_reset(1'b0);
    btn_state[2] = 1'b1;
    ticks(24);
    n_chk++;
    if (ev_valid !== 1'b1 || ev_btn !== 2'd2 || ev_code !== 2'd1)
      $display("FAIL midheld_pre: got v=%b btn=%0d code=%0d want v=1 btn=2 code=1", ev_valid, ev_btn, ev_code);
    else n_pass++;
    #2;
    rst = 1'b1;
    #1;
    n_chk++;
    if (ev_valid !== 1'b0 || ev_btn !== 2'd0 || ev_code !== 2'd0 || overflow !== 1'b0)
      $display("FAIL midheld_reset: got v=%b btn=%0d code=%0d ovf=%b want all 0", ev_valid, ev_btn, ev_code, overflow);
    else n_pass++;
    tick();
    rst = 1'b0;
    ev_ready = 1'b1;
    ticks(5);
    btn_state[2] = 1'b0;
    for (int t = 0; t < 10; t++) begin
      tick();
      if (ev_valid) seen++;
    end
    n_chk++;
    if (seen !== 0) $display("FAIL midheld_after: got %0d valid cycles want 0", seen);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_short();
    test_long();
    test_round_robin();
    test_overflow();
    test_hold_through_reset();
    test_reset_mid_held();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
